maze_collision_checker: RTL and testbench

- Combined maze-wall collision checker and free-running clock divider used by the sprite movers (ghosts, Pac-Man).
- Given a sprite's top-left position and a move direction, it reports each cycle whether a one-pixel step in that direction is legal.
- It also exports a 32-bit divide-by-2^n counter, which movers use for slow-rate ticks.

---
 rtl/maze_collision_checker.sv | 103 ++++++++++
 tb/tb_maze_collision_checker.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/maze_collision_checker.sv
// Maze-wall collision checker with a free-running 32-bit cycle counter.
// Each cycle it registers whether a one-pixel step from the sprite's
// top-left position in the requested direction lands on free floor.
module maze_collision_checker #(
  parameter int TILE         = 16,
  parameter int SPRITE       = 16,
  parameter int SCREEN_W     = 640,
  parameter int SCREEN_H     = 480,
  parameter int PILLAR_PITCH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  pos_x,
  input  logic [8:0]  pos_y,
  input  logic [1:0]  dir,
  output logic        result,
  output logic [31:0] clkdiv
);

  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_LEFT  = 2'b10,
    DIR_RIGHT = 2'b11
  } dir_t;

  localparam int COLS = SCREEN_W / TILE;
  localparam int ROWS = SCREEN_H / TILE;
  localparam int TSH  = $clog2(TILE);
  localparam int PSH  = $clog2(PILLAR_PITCH);
  // Tile index width after dropping the in-tile pixel bits of a 12-bit coordinate.
  localparam int TW   = 12 - TSH;

  // 12-bit signed leaves headroom for 1023+1 and for far-edge sums such as
  // 1020+15, so neither the underflow nor the overflow case can wrap.
  localparam logic signed [11:0] SPAN  = 12'(SPRITE - 1);
  localparam logic signed [11:0] X_MAX = 12'(SCREEN_W - 1);
  localparam logic signed [11:0] Y_MAX = 12'(SCREEN_H - 1);

  logic signed [11:0] cand_x, cand_y;
  logic signed [11:0] far_x, far_y;
  logic               out_of_bounds;
  logic               wall_hit;
  logic               blocked;
  logic [TW-1:0]      col_lo, col_hi, row_lo, row_hi;
  logic [31:0]        count;

  // Wall map: border ring of tiles plus a regular grid of interior pillars.
  function automatic logic is_wall(input logic [TW-1:0] c, input logic [TW-1:0] r);
    logic border, pillar;
    border = (c == '0) || (c == TW'(COLS - 1)) || (r == '0) || (r == TW'(ROWS - 1));
    pillar = (c[PSH-1:0] == '0) && (r[PSH-1:0] == '0);
    return border || pillar;
  endfunction

  // Candidate box, its bounds test and the four corner-tile wall lookups.
  always_comb begin
    // NOTE: every signal written here gets a value on every path, starting
    // with these defaults, so no latch can be inferred.
    cand_x = $signed({2'b00, pos_x});
    cand_y = $signed({3'b000, pos_y});
    unique case (dir_t'(dir))
      DIR_UP:    cand_y = cand_y - 12'sd1;
      DIR_DOWN:  cand_y = cand_y + 12'sd1;
      DIR_LEFT:  cand_x = cand_x - 12'sd1;
      DIR_RIGHT: cand_x = cand_x + 12'sd1;
    endcase

    far_x = cand_x + SPAN;
    far_y = cand_y + SPAN;

    out_of_bounds = cand_x[11] || cand_y[11] || (far_x > X_MAX) || (far_y > Y_MAX);

    // Tile indices are only meaningful when the box is on screen; the
    // bounds term masks them otherwise.
    col_lo = cand_x[11:TSH];
    col_hi = far_x[11:TSH];
    row_lo = cand_y[11:TSH];
    row_hi = far_y[11:TSH];

    // Corners suffice: a box no larger than a tile cannot straddle a wall
    // tile without one of its corners landing inside it.
    wall_hit = is_wall(col_lo, row_lo) || is_wall(col_lo, row_hi) ||
               is_wall(col_hi, row_lo) || is_wall(col_hi, row_hi);

    blocked = out_of_bounds || wall_hit;
  end

  // Registered verdict and free-running counter, both cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count  <= '0;
      result <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      count  <= count + 32'd1;
      result <= ~blocked;
    end
  end

  assign clkdiv = count;

endmodule

// File: tb/tb_maze_collision_checker.sv
// Self-checking bench: directed vectors from the test plan, then random
// vectors compared against a tile-map model written with plain integers.
module tb_maze_collision_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [9:0]  pos_x = '0;
  logic [8:0]  pos_y = '0;
  logic [1:0]  dir = '0;
  logic        result;
  logic [31:0] clkdiv;

  int n_cmp  = 0;
  int n_fail = 0;

  maze_collision_checker dut (
    .clk    (clk),
    .rst    (rst),
    .pos_x  (pos_x),
    .pos_y  (pos_y),
    .dir    (dir),
    .result (result),
    .clkdiv (clkdiv)
  );

  always #5 clk = ~clk;

  // Playfield model: 40x30 tiles of 16 px, border ring plus pillars every 4 tiles.
  function automatic bit wall(int c, int r);
    return (c == 0) || (c == 39) || (r == 0) || (r == 29) ||
           ((c % 4 == 0) && (r % 4 == 0));
  endfunction

  function automatic bit model_free(int x, int y, int d);
    int xp, yp;
    xp = x;
    yp = y;
    case (d)
      0: yp = yp - 1;
      1: yp = yp + 1;
      2: xp = xp - 1;
      default: xp = xp + 1;
    endcase
    if (xp < 0 || yp < 0 || xp + 15 > 639 || yp + 15 > 479) return 1'b0;
    if (wall(xp / 16, yp / 16) || wall((xp + 15) / 16, yp / 16) ||
        wall(xp / 16, (yp + 15) / 16) || wall((xp + 15) / 16, (yp + 15) / 16))
      return 1'b0;
    return 1'b1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present a vector after a falling edge, check the registered verdict just after the next rising edge.
  task automatic step(input string tag, input int x, input int y, input int d);
    @(negedge clk);
    pos_x = 10'(x);
    pos_y = 9'(y);
    dir   = 2'(d);
    @(posedge clk);
    #1;
    check($sformatf("%s(%0d,%0d,%0d)", tag, x, y, d), {31'b0, result}, {31'b0, model_free(x, y, d)});
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] snap;
    int x, y, d;

    // Power-up under reset.
    #1;
    check("reset_clkdiv", clkdiv, 32'd0);
    check("reset_result", {31'b0, result}, 32'd0);
    pos_x = 10'd320; pos_y = 9'd240; dir = 2'b11;
    repeat (3) @(posedge clk);
    #1;
    check("held_clkdiv", clkdiv, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("count_after_5", clkdiv, 32'd5);
    check("free_before_reset", {31'b0, result}, 32'd1);

    // Asynchronous reset mid-cycle: outputs clear before any edge.
    #2;
    rst = 1'b0;
    #1;
    check("async_clkdiv", clkdiv, 32'd0);
    check("async_result", {31'b0, result}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("held2_clkdiv", clkdiv, 32'd0);
    check("held2_result", {31'b0, result}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("restart_5", clkdiv, 32'd5);

    // Directed vectors from the test plan.
    step("free_move",   320, 240, 3);
    step("col0_wall",    16, 240, 2);
    step("row0_wall",    16,  16, 0);
    step("row29_wall",  344, 448, 1);
    step("pillar_edge",  47,  64, 3);
    step("pillar_hit",   48,  64, 3);
    step("underflow_x",   0, 100, 2);
    step("underflow_y", 100,   0, 0);
    step("right_edge",  624, 100, 3);
    step("max_x",      1023, 100, 3);

    // Back-to-back alternation: verdict must follow each vector with one cycle lag.
    for (int i = 0; i < 6; i++) begin
      step("b2b_blocked", 48, 64, 3);
      step("b2b_free",   320, 240, 3);
    end

    // Random vectors, mostly on-screen so wall hits dominate over bounds hits.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        x = $urandom_range(0, 630);
        y = $urandom_range(0, 470);
      end else begin
        x = $urandom_range(0, 1023);
        y = $urandom_range(0, 511);
      end
      d = $urandom_range(0, 3);
      step("rand", x, y, d);
    end

    // Counter keeps advancing one per edge.
    @(negedge clk);
    snap = clkdiv;
    repeat (10) @(posedge clk);
    #1;
    check("count_delta", clkdiv, snap + 32'd10);

    // Bit 17 rises at 131072: preload just below it.
    @(negedge clk);
    force dut.count = 32'h0001_FFFF;
    #1;
    release dut.count;
    @(posedge clk);
    #1;
    check("bit17_rise", {31'b0, clkdiv[17]}, 32'd1);
    check("bit17_value", clkdiv, 32'h0002_0000);

    // Wrap from all-ones to zero.
    @(negedge clk);
    force dut.count = 32'hFFFF_FFFF;
    #1;
    release dut.count;
    @(posedge clk);
    #1;
    check("wrap", clkdiv, 32'd0);
    @(posedge clk);
    #1;
    check("after_wrap", clkdiv, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
